// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the pixel-stream taps.
package vga_pkg;

  localparam int          HOR_PIXELS   = 1024;
  localparam int          VER_PIXELS   = 768;
  localparam logic [11:0] WALL_RGB_DEF = 12'h00f;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic hit;
  } probe_flags_t;

  typedef enum logic [1:0] {
    SYNC,
    ACTIVE,
    REPORT
  } probe_state_t;

endpackage

// File: rtl/probe_region_cmp.sv
// Classifies one screen coordinate against the object rectangle and the
// 1-px ring around it; ring segments span the object extent only.
module probe_region_cmp #(
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32
) (
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic [10:0] i_obj_x,
  input  logic [10:0] i_obj_y,
  output logic        o_in_obj,
  output logic        o_ring_up,
  output logic        o_ring_down,
  output logic        o_ring_left,
  output logic        o_ring_right
);

  logic [11:0] w_h;
  logic [11:0] w_v;
  logic [11:0] w_x0;
  logic [11:0] w_y0;
  logic [11:0] w_x1;
  logic [11:0] w_y1;
  logic        w_in_cols;
  logic        w_in_rows;

  assign w_h  = {1'b0, i_hcount};
  assign w_v  = {1'b0, i_vcount};
  assign w_x0 = {1'b0, i_obj_x};
  assign w_y0 = {1'b0, i_obj_y};
  // First column/row past the object, i.e. the right/bottom ring lines.
  assign w_x1 = w_x0 + 12'(OBJ_W);
  assign w_y1 = w_y0 + 12'(OBJ_H);

  assign w_in_cols = (w_h >= w_x0) && (w_h < w_x1);
  assign w_in_rows = (w_v >= w_y0) && (w_v < w_y1);

  assign o_in_obj = w_in_cols && w_in_rows;
  // Compare coord+1 against the origin so an origin of 0 never wraps.
  assign o_ring_up    = w_in_cols && ((w_v + 12'd1) == w_y0);
  assign o_ring_down  = w_in_cols && (w_v == w_y1);
  assign o_ring_left  = w_in_rows && ((w_h + 12'd1) == w_x0);
  assign o_ring_right = w_in_rows && (w_h == w_x1);

endmodule

// File: rtl/vga_wall_probe.sv
// Read-only tap on the final VGA pixel stream: per frame it reports wall
// contact around and inside a movable object rectangle.
module vga_wall_probe
  import vga_pkg::*;
#(
  parameter int          OBJ_W    = 32,
  parameter int          OBJ_H    = 32,
  parameter logic [11:0] WALL_RGB = WALL_RGB_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      i_hcount,
  input  logic [10:0]      i_vcount,
  input  logic             i_hblnk,
  input  logic             i_vblnk,
  input  logic [11:0]      i_rgb,
  input  logic [10:0]      obj_x,
  input  logic [10:0]      obj_y,
  output logic             blocked_up,
  output logic             blocked_down,
  output logic             blocked_left,
  output logic             blocked_right,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             frame_valid
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [10:0]      r_hcount_p1;
  logic [10:0]      r_vcount_p1;
  logic             r_hblnk_p1;
  logic [11:0]      r_rgb_p1;
  logic             r_vblnk_p1;
  logic             r_vblnk_q;

  probe_state_t     r_state;
  probe_state_t     w_state_nxt;
  logic             w_clr;
  logic             w_latch;
  logic             w_load;

  logic [10:0]      r_obj_x;
  logic [10:0]      r_obj_y;
  probe_flags_t     r_acc;
  logic [CNT_W-1:0] r_cnt;
  probe_flags_t     r_out;
  logic [CNT_W-1:0] r_hit_count;
  probe_flags_t     w_out_nxt;

  logic             w_in_obj;
  logic             w_ring_up;
  logic             w_ring_down;
  logic             w_ring_left;
  logic             w_ring_right;
  logic             w_pix_wall;
  logic             w_frame_end;
  logic [11:0]      w_obj_bot;
  logic [11:0]      w_obj_rgt;

  // Stage 1: register the stream; vblnk held high through reset so a reset
  // during blanking cannot fake a frame edge.
  always_ff @(posedge clk) begin
    r_hcount_p1 <= i_hcount;
    r_vcount_p1 <= i_vcount;
    r_hblnk_p1  <= i_hblnk;
    r_rgb_p1    <= i_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_p1 <= 1'b1;
      r_vblnk_q  <= 1'b1;
    end else begin
      r_vblnk_p1 <= i_vblnk;
      r_vblnk_q  <= r_vblnk_p1;
    end
  end

  // Stage 2: classify the registered pixel against the latched object.
  probe_region_cmp #(
    .OBJ_W(OBJ_W),
    .OBJ_H(OBJ_H)
  ) u_cmp (
    .i_hcount    (r_hcount_p1),
    .i_vcount    (r_vcount_p1),
    .i_obj_x     (r_obj_x),
    .i_obj_y     (r_obj_y),
    .o_in_obj    (w_in_obj),
    .o_ring_up   (w_ring_up),
    .o_ring_down (w_ring_down),
    .o_ring_left (w_ring_left),
    .o_ring_right(w_ring_right)
  );

  assign w_pix_wall  = ~r_hblnk_p1 & ~r_vblnk_p1 & (r_rgb_p1 == WALL_RGB);
  assign w_frame_end = r_vblnk_p1 & ~r_vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      SYNC: begin
        if (w_frame_end) begin
          w_state_nxt = ACTIVE;
          w_clr       = 1'b1;
          w_latch     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_frame_end) begin
          w_state_nxt = REPORT;
          w_load      = 1'b1;
        end
      end
      REPORT: begin
        w_state_nxt = ACTIVE;
        w_clr       = 1'b1;
        w_latch     = 1'b1;
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  // Screen-edge rule is folded in when the frame result is published.
  assign w_obj_bot = {1'b0, r_obj_y} + 12'(OBJ_H);
  assign w_obj_rgt = {1'b0, r_obj_x} + 12'(OBJ_W);

  always_comb begin
    w_out_nxt.up    = r_acc.up    | (r_obj_y == 11'd0);
    w_out_nxt.down  = r_acc.down  | (w_obj_bot >= 12'(VER_PIXELS));
    w_out_nxt.left  = r_acc.left  | (r_obj_x == 11'd0);
    w_out_nxt.right = r_acc.right | (w_obj_rgt >= 12'(HOR_PIXELS));
    w_out_nxt.hit   = r_acc.hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_obj_x     <= '0;
      r_obj_y     <= '0;
      r_out       <= '0;
      r_hit_count <= '0;
    end else begin
      if (w_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_pix_wall) begin
        r_acc.up    <= r_acc.up    | w_ring_up;
        r_acc.down  <= r_acc.down  | w_ring_down;
        r_acc.left  <= r_acc.left  | w_ring_left;
        r_acc.right <= r_acc.right | w_ring_right;
        if (w_in_obj) begin
          r_acc.hit <= 1'b1;
          r_cnt     <= sat_inc(r_cnt);
        end
      end
      if (w_latch) begin
        r_obj_x <= obj_x;
        r_obj_y <= obj_y;
      end
      if (w_load) begin
        r_out       <= w_out_nxt;
        r_hit_count <= r_cnt;
      end
    end
  end

  assign blocked_up    = r_out.up;
  assign blocked_down  = r_out.down;
  assign blocked_left  = r_out.left;
  assign blocked_right = r_out.right;
  assign hit           = r_out.hit;
  assign hit_count     = r_hit_count;
  assign frame_valid   = (r_state == REPORT);

endmodule

// File: tb/tb_vga_wall_probe.sv
// Bench for vga_wall_probe: windowed synthetic 1024x768 frames, directed
// table rows, multi-cycle corner sequences and randomized frames vs a model.
module tb_vga_wall_probe;

  localparam int          OBJ_W = 32;
  localparam int          OBJ_H = 32;
  localparam logic [11:0] WALL  = 12'h00f;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount, obj_x, obj_y;
  logic        hblnk, vblnk;
  logic [11:0] rgb;
  logic        up, down, left, right, hit, fv;
  logic [15:0] cnt;
  logic        s_up, s_down, s_left, s_right, s_hit, s_fv;
  logic [3:0]  s_cnt;

  vga_wall_probe u_dut (
    .clk(clk), .rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_hblnk(hblnk), .i_vblnk(vblnk), .i_rgb(rgb), .obj_x(obj_x), .obj_y(obj_y),
    .blocked_up(up), .blocked_down(down), .blocked_left(left),
    .blocked_right(right), .hit(hit), .hit_count(cnt), .frame_valid(fv)
  );

  vga_wall_probe #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .i_hcount(hcount), .i_vcount(vcount),
    .i_hblnk(hblnk), .i_vblnk(vblnk), .i_rgb(rgb), .obj_x(obj_x), .obj_y(obj_y),
    .blocked_up(s_up), .blocked_down(s_down), .blocked_left(s_left),
    .blocked_right(s_right), .hit(s_hit), .hit_count(s_cnt), .frame_valid(s_fv)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          pulse_cyc = 0;
  logic [4:0]  cap_f, cap_sf;
  logic [15:0] cap_cnt;
  logic [3:0]  cap_scnt;
  logic        cap_sfv;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fv) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc + 1;
      cap_f     <= {up, down, left, right, hit};
      cap_cnt   <= cnt;
      cap_sf    <= {s_up, s_down, s_left, s_right, s_hit};
      cap_scnt  <= s_cnt;
      cap_sfv   <= s_fv;
    end
  end

  // Reference model: object latched at each frame end, ring/inside rules
  // evaluated with plain integer arithmetic over every counted pixel.
  logic m_synced;
  int   m_ox, m_oy, a_cnt, wall_sel;
  logic a_up, a_down, a_left, a_right;

  typedef struct {
    int         ox;
    int         oy;
    int         wsel;
    logic [4:0] f;
    int         cnt;
  } vec_t;
  vec_t tab[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] wall_at(input int x, input int y);
    if (wall_sel == 1 && x >= 128 && x <= 132 && y >= 60 && y <= 130) return WALL;
    if (wall_sel == 2 && x >= 200 && x <= 209 && y >= 300 && y <= 309) return WALL;
    return 12'h000;
  endfunction

  task automatic model_clear();
    a_up = 0; a_down = 0; a_left = 0; a_right = 0; a_cnt = 0;
  endtask

  task automatic model_pix(input int x, input int y, input logic [11:0] r);
    logic in_c, in_r;
    if (r != WALL) return;
    in_c = (x >= m_ox) && (x < m_ox + OBJ_W);
    in_r = (y >= m_oy) && (y < m_oy + OBJ_H);
    if (in_c && in_r) a_cnt++;
    if (in_c && y == m_oy - 1) a_up = 1;
    if (in_c && y == m_oy + OBJ_H) a_down = 1;
    if (in_r && x == m_ox - 1) a_left = 1;
    if (in_r && x == m_ox + OBJ_W) a_right = 1;
  endtask

  task automatic end_frame(input string tag);
    int         p0, vb, sc;
    logic [4:0] ef;
    p0 = pulses;
    vb = cyc + 1;
    hblnk = 1; vblnk = 1; rgb = WALL;
    hcount = 11'(m_ox); vcount = 11'(m_oy);
    repeat (6) tick();
    ef = {a_up | (m_oy == 0), a_down | (m_oy + OBJ_H >= 768),
          a_left | (m_ox == 0), a_right | (m_ox + OBJ_W >= 1024), a_cnt != 0};
    sc = (a_cnt > 15) ? 15 : a_cnt;
    if (m_synced) begin
      chk({tag, "_pulse"}, pulses - p0, 1);
      chk({tag, "_latency"}, pulse_cyc - vb, 2);
      chk({tag, "_flags"}, {27'd0, cap_f}, {27'd0, ef});
      chk({tag, "_count"}, {16'd0, cap_cnt}, a_cnt);
      chk({tag, "_sat"}, {22'd0, cap_sfv, cap_sf, cap_scnt}, {22'd0, 1'b1, ef, 4'(sc)});
      chk({tag, "_hold"}, {10'd0, up, down, left, right, hit, cnt, fv},
          {10'd0, ef, 16'(a_cnt), 1'b0});
    end else begin
      chk({tag, "_nopulse"}, pulses - p0, 0);
    end
    m_synced = 1;
    m_ox = int'(obj_x);
    m_oy = int'(obj_y);
    model_clear();
  endtask

  task automatic drive_frame(input string tag, input int x0, input int x1,
                             input int y0, input int y1, input int mode,
                             input int chg_row, input int chg_x, input int rst_row);
    logic [11:0] r;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (y == chg_row && x == x0) obj_x = 11'(chg_x);
        if (y == rst_row && x == x0) begin
          rst = 1;
          tick();
          chk({tag, "_rst_out"}, {9'd0, fv, up, down, left, right, hit, cnt}, 32'd0);
          rst = 0;
          m_synced = 0; m_ox = 0; m_oy = 0;
          model_clear();
        end
        r = (mode == 1) ? (($urandom_range(0, 2) == 0) ? WALL : 12'($urandom_range(0, 4095)))
                        : wall_at(x, y);
        hcount = 11'(x); vcount = 11'(y); rgb = r; vblnk = 0;
        hblnk = (mode == 1 && $urandom_range(0, 15) == 0);
        if (!hblnk) model_pix(x, y, r);
        tick();
      end
      hcount = 11'(x1 + 1); vcount = 11'(y); rgb = WALL; hblnk = 1; vblnk = 0;
      tick();
    end
    end_frame(tag);
  endtask

  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

  task automatic frame_around(input string tag, input int mode);
    drive_frame(tag, imax(0, m_ox - 2), imin(1023, m_ox + OBJ_W + 1),
                imax(0, m_oy - 2), imin(767, m_oy + OBJ_H + 1), mode, -1, 0, -1);
  endtask

  task automatic latch_frame(input string tag);
    drive_frame(tag, 0, 3, 700, 700, 0, -1, 0, -1);
  endtask

  initial begin
    tab[0] = '{ox: 96,  oy: 80,  wsel: 1, f: 5'b00010, cnt: 0};
    tab[1] = '{ox: 195, oy: 295, wsel: 2, f: 5'b00001, cnt: 100};
    tab[2] = '{ox: 0,   oy: 0,   wsel: 0, f: 5'b10100, cnt: 0};
    tab[3] = '{ox: 992, oy: 736, wsel: 0, f: 5'b01010, cnt: 0};

    rst = 1; hcount = 0; vcount = 0; hblnk = 1; vblnk = 1; rgb = 0;
    obj_x = 0; obj_y = 0; wall_sel = 0;
    m_synced = 0; m_ox = 0; m_oy = 0;
    model_clear();
    repeat (3) tick();
    chk("reset_outputs", {9'd0, fv, up, down, left, right, hit, cnt}, 32'd0);
    chk("reset_sat_outputs", {26'd0, s_fv, s_up, s_down, s_left, s_right, s_hit}, 32'd0);
    rst = 0;
    tick();

    // Two frames after reset: first edge silent, second reports all clear.
    obj_x = 500; obj_y = 400;
    frame_around("first_edge", 0);
    frame_around("second_edge", 0);
    chk("second_edge_zero", {11'd0, cap_f, cap_cnt}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      obj_x = 11'(tab[i].ox); obj_y = 11'(tab[i].oy); wall_sel = tab[i].wsel;
      latch_frame("tab_latch");
      frame_around("tab_report", 0);
      chk($sformatf("tab%0d_flags", i), {27'd0, cap_f}, {27'd0, tab[i].f});
      chk($sformatf("tab%0d_count", i), {16'd0, cap_cnt}, tab[i].cnt);
    end

    // obj_x moves mid-frame; that frame still reports the old position.
    wall_sel = 1; obj_x = 96; obj_y = 80;
    latch_frame("mid_latch");
    drive_frame("mid_change", 92, 131, 76, 403, 0, 400, 300, -1);
    chk("mid_old_right", {31'd0, cap_f[1]}, 32'd1);
    frame_around("mid_next", 0);
    chk("mid_new_right", {31'd0, cap_f[1]}, 32'd0);

    // Reset in the middle of a frame after a non-zero report.
    obj_x = 96;
    latch_frame("rst_latch");
    frame_around("rst_pre", 0);
    drive_frame("rst_mid", 92, 131, 76, 205, 0, -1, 0, 200);
    frame_around("rst_after", 0);
    chk("rst_after_right", {31'd0, cap_f[1]}, 32'd1);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       obj_x = 11'($urandom_range(0, 1));
        1:       obj_x = 11'($urandom_range(988, 1023));
        default: obj_x = 11'($urandom_range(2, 987));
      endcase
      case ($urandom_range(0, 3))
        0:       obj_y = 11'($urandom_range(0, 1));
        1:       obj_y = 11'($urandom_range(732, 767));
        default: obj_y = 11'($urandom_range(2, 731));
      endcase
      frame_around($sformatf("rand%0d", k), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
